vai_tx_arbiter: RTL and testbench

- Round-robin arbiter sharing one upstream CCI-P Tx request channel between NUM_SUB_AFUS sub-AFU requesters.
- Sits inside the multiplexer, between the per-AFU Tx ports and the registered upstream Tx port.
- Honours upstream almost-full backpressure.
- Enforces a per-requester outstanding-request cap, tracked via responses tagged with the requester ID.

---
 rtl/vai_arb_pkg.sv | 15 +
 rtl/vai_rr_picker.sv | 36 +++
 rtl/vai_tx_arbiter.sv | 97 +++++++++
 tb/tb_vai_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vai_arb_pkg.sv
// Shared definitions for the VAI Tx/Rx arbitration blocks: ID width helper,
// requester ID type and the default outstanding-request cap.
package vai_arb_pkg;

  localparam int VAI_DEFAULT_MAX_OUTSTANDING = 8;
  localparam int VAI_MAX_SUB_AFUS            = 16;

  // Requester ID width, never narrower than one bit.
  function automatic int vai_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(VAI_MAX_SUB_AFUS)-1:0] t_vai_req_id;

endpackage

// File: rtl/vai_rr_picker.sv
// Rotate-priority one-hot picker: the first eligible index at or after rr_ptr
// (wrapping modulo N) wins. Purely combinational.
module vai_rr_picker
  import vai_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = vai_id_w(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] winner,
  output logic            any_grant
);

  int idx;

  // Scan from the farthest offset down so the nearest eligible index wins.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = int'(rr_ptr) + off;
      if (idx >= N) idx = idx - N;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        winner     = ID_W'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vai_tx_arbiter.sv
// Round-robin arbiter sharing one registered upstream Tx request channel among
// NUM_SUB_AFUS requesters, with almost-full backpressure and per-requester caps.
module vai_tx_arbiter
  import vai_arb_pkg::*;
#(
  parameter int NUM_SUB_AFUS    = 4,
  parameter int REQ_W           = 512,
  parameter int MAX_OUTSTANDING = VAI_DEFAULT_MAX_OUTSTANDING,
  parameter int ID_W            = vai_id_w(NUM_SUB_AFUS)
) (
  input  logic                          pClk,
  input  logic                          pck_cp2af_softReset_n,
  input  logic [NUM_SUB_AFUS-1:0]       req_valid,
  input  logic [NUM_SUB_AFUS*REQ_W-1:0] req_data,
  output logic [NUM_SUB_AFUS-1:0]       req_ready,
  output logic                          up_valid,
  output logic [REQ_W-1:0]              up_data,
  output logic [ID_W-1:0]               up_id,
  input  logic                          up_almfull,
  input  logic                          rsp_valid,
  input  logic [ID_W-1:0]               rsp_id,
  output logic [NUM_SUB_AFUS-1:0]       outstanding_full,
  output logic                          err_underflow
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Handshake: requester i transfers in the cycle req_valid[i] & req_ready[i];
  // it holds req_data while valid and ungranted and never drops valid ungranted.
  // Upstream has no ready: up_valid is a one-cycle pulse per issued request.

  logic [NUM_SUB_AFUS-1:0] eligible;
  logic [NUM_SUB_AFUS-1:0] grant;
  logic [NUM_SUB_AFUS-1:0] underflow_hit;
  logic [ID_W-1:0]         winner;
  logic [ID_W-1:0]         rr_ptr;
  logic                    any_grant;
  logic                    fire;
  logic                    rsp_in_range;

  vai_rr_picker #(.N(NUM_SUB_AFUS), .ID_W(ID_W)) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .winner   (winner),
    .any_grant(any_grant)
  );

  assign fire         = any_grant & ~up_almfull;
  assign req_ready    = fire ? grant : '0;
  assign rsp_in_range = int'(rsp_id) < NUM_SUB_AFUS;

  for (genvar i = 0; i < NUM_SUB_AFUS; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;
    logic             inc;
    logic             dec;

    assign inc = fire && (winner == ID_W'(i));
    assign dec = rsp_valid && rsp_in_range && (rsp_id == ID_W'(i));

    assign eligible[i]         = req_valid[i] && (cnt < CNT_W'(MAX_OUTSTANDING));
    assign outstanding_full[i] = (cnt == CNT_W'(MAX_OUTSTANDING));
    assign underflow_hit[i]    = dec && !inc && (cnt == '0);

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
      if (!pck_cp2af_softReset_n) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        cnt <= cnt + 1'b1;
      end else if (dec && !inc && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      up_valid      <= 1'b0;
      up_data       <= '0;
      up_id         <= '0;
      rr_ptr        <= '0;
      err_underflow <= 1'b0;
    end else begin
      up_valid <= fire;
      if (fire) begin
        up_data <= req_data[int'(winner)*REQ_W +: REQ_W];
        up_id   <= winner;
        rr_ptr  <= (winner == ID_W'(NUM_SUB_AFUS - 1)) ? '0 : winner + 1'b1;
      end
      // Responses with no matching outstanding request latch the error.
      if ((|underflow_hit) || (rsp_valid && !rsp_in_range)) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vai_tx_arbiter.sv
// Self-checking bench for vai_tx_arbiter: directed phases plus a randomized
// phase, all checked against a behavioural model of the arbitration rules.
module tb_vai_tx_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MAX = 2;

  logic           pClk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           up_valid;
  logic [W-1:0]   up_data;
  logic [1:0]     up_id;
  logic           up_almfull;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [N-1:0]   outstanding_full;
  logic           err_underflow;

  vai_tx_arbiter #(.NUM_SUB_AFUS(N), .REQ_W(W), .MAX_OUTSTANDING(MAX)) dut (
    .pClk                 (pClk),
    .pck_cp2af_softReset_n(rst_n),
    .req_valid            (req_valid),
    .req_data             (req_data),
    .req_ready            (req_ready),
    .up_valid             (up_valid),
    .up_data              (up_data),
    .up_id                (up_id),
    .up_almfull           (up_almfull),
    .rsp_valid            (rsp_valid),
    .rsp_id               (rsp_id),
    .outstanding_full     (outstanding_full),
    .err_underflow        (err_underflow)
  );

  // clock / reset
  always #5 pClk = ~pClk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_grant = -1;

  // reference model state
  int           m_cnt[N];
  int           m_ptr;
  bit           m_err;
  logic [W-1:0] m_ud;
  int           m_uid;
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  int           who_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] e, input int p);
    for (int k = 0; k < N; k++) begin
      if (e[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ptr = 0; m_err = 0; m_ud = '0; m_uid = 0; last_grant = -1;
    exp_q.delete(); due_q.delete(); who_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    up_almfull = 1'b0; rsp_valid = 1'b0; rsp_id = '0;
    model_reset();
    repeat (2) @(negedge pClk);
    rst_n = 1'b1;
  endtask

  // driver tasks (called at the falling edge)
  task automatic drive_reqs(input logic [N-1:0] mask, input bit rnd);
    for (int i = 0; i < N; i++) begin
      if (!(req_valid[i] && last_grant != i)) begin
        req_valid[i] = rnd ? 1'($urandom_range(0, 1)) : mask[i];
        req_data[i*W +: W] = $urandom;
      end
    end
  endtask

  task automatic sched_rsp();
    rsp_valid = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      rsp_valid = 1'b1;
      rsp_id = 2'(who_q.pop_front());
      void'(due_q.pop_front());
    end
  endtask

  task automatic rand_rsp();
    int busy[$];
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) busy.push_back(i);
    rsp_valid = (busy.size() > 0) && ($urandom_range(0, 1) == 1);
    if (rsp_valid) rsp_id = 2'(busy[$urandom_range(0, busy.size() - 1)]);
  endtask

  // one clock cycle: check combinational outputs, advance model, check registers
  task automatic cycle();
    int g;
    logic [N-1:0] elig, exp_full, exp_rdy;
    bit inc, dec;
    #1;
    for (int i = 0; i < N; i++) begin
      elig[i]     = req_valid[i] && (m_cnt[i] < MAX);
      exp_full[i] = (m_cnt[i] == MAX);
    end
    g = up_almfull ? -1 : pick(elig, m_ptr);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("outstanding_full", outstanding_full, exp_full);
    chk("err_underflow", err_underflow, m_err);
    @(posedge pClk);
    if (g >= 0) begin
      exp_q.push_back(req_data[g*W +: W]);
      m_ud  = req_data[g*W +: W];
      m_uid = g;
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      inc = (g == i);
      dec = rsp_valid && (int'(rsp_id) == i);
      if (inc && !dec) m_cnt[i]++;
      else if (dec && !inc) begin
        if (m_cnt[i] == 0) m_err = 1;
        else m_cnt[i]--;
      end
    end
    last_grant = g;
    #1;
    chk("up_valid", up_valid, g >= 0);
    if (g >= 0) chk("up_data", up_data, exp_q.pop_front());
    else chk("up_data_hold", up_data, m_ud);
    chk("up_id", up_id, m_uid);
    cyc++;
    @(negedge pClk);
  endtask

  initial begin
    int pulses, k, grants;
    do_reset();

    // post-reset idle
    repeat (10) cycle();

    // fairness with responses three cycles after each grant
    pulses = 0; k = 0;
    repeat (24) begin
      drive_reqs(4'hF, 0);
      sched_rsp();
      cycle();
      if (last_grant >= 0) begin due_q.push_back(cyc + 2); who_q.push_back(last_grant); end
      if (up_valid) begin
        pulses++;
        chk("fair_seq", up_id, k % N);
        k++;
      end
    end
    chk("fair_pulses", pulses, 24);

    // outstanding cap on requester 2
    do_reset();
    grants = 0;
    repeat (6) begin
      drive_reqs(4'b0100, 0);
      cycle();
      if (up_valid) grants++;
    end
    chk("cap_grants", grants, 2);
    chk("cap_full", outstanding_full, 4'b0100);
    chk("cap_ready", req_ready, 4'b0000);
    drive_reqs(4'b0100, 0);
    rsp_valid = 1'b1; rsp_id = 2'd2;
    cycle();
    rsp_valid = 1'b0;
    chk("cap_rsp_cycle", up_valid, 1'b0);
    drive_reqs(4'b0100, 0);
    cycle();
    chk("cap_regrant", up_valid, 1'b1);
    drive_reqs(4'b0100, 0);
    cycle();
    chk("cap_after", up_valid, 1'b0);

    // almost-full window in cycles 5..9
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive_reqs(4'hF, 0);
      sched_rsp();
      up_almfull = (c >= 5 && c <= 9);
      cycle();
      if (last_grant >= 0) begin due_q.push_back(cyc + 2); who_q.push_back(last_grant); end
      chk("almfull_up_valid", up_valid, !(c >= 5 && c <= 9));
      if (c == 10) chk("almfull_resume_id", up_id, 1);
    end
    up_almfull = 1'b0;

    // grant and response to the same requester in one cycle
    do_reset();
    rsp_valid = 1'b0;
    drive_reqs(4'b0010, 0);
    cycle();
    drive_reqs(4'b0010, 0);
    rsp_valid = 1'b1; rsp_id = 2'd1;
    cycle();
    rsp_valid = 1'b0;
    chk("simul_up_valid", up_valid, 1'b1);
    chk("simul_err", err_underflow, 1'b0);
    drive_reqs(4'b0010, 0);
    cycle();
    chk("simul_full", outstanding_full, 4'b0010);

    // randomized traffic
    do_reset();
    repeat (400) begin
      drive_reqs('0, 1);
      rand_rsp();
      up_almfull = ($urandom_range(0, 4) == 0);
      cycle();
    end

    // underflow is sticky
    do_reset();
    rsp_valid = 1'b1; rsp_id = 2'd3;
    cycle();
    rsp_valid = 1'b0;
    chk("underflow_set", err_underflow, 1'b1);
    repeat (3) cycle();
    chk("underflow_sticky", err_underflow, 1'b1);

    // asynchronous reset in the middle of a burst
    repeat (3) begin
      drive_reqs(4'hF, 0);
      cycle();
    end
    chk("pre_reset_up_valid", up_valid, 1'b1);
    rst_n = 1'b0; req_valid = '0;
    #1;
    chk("rst_up_valid", up_valid, 1'b0);
    chk("rst_up_data", up_data, '0);
    chk("rst_up_id", up_id, 2'd0);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_full", outstanding_full, 4'b0000);
    chk("rst_err", err_underflow, 1'b0);
    model_reset();
    @(negedge pClk);
    rst_n = 1'b1;
    rsp_valid = 1'b1; rsp_id = 2'd0;
    cycle();
    rsp_valid = 1'b0;
    chk("post_reset_rsp_err", err_underflow, 1'b1);
    repeat (2) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
